updown_counter_mod: RTL and testbench

- Parametrised up/down counter with a runtime modulus, selectable wrap or saturate mode, synchronous load and a registered terminal-count pulse.
- Next-generation replacement for the basic load/enable counter. Used as a timer, event counter or address generator inside datapath blocks.
- Flag outputs allow several instances to be chained or monitored.

---
 rtl/udcnt_pkg.sv | 19 +
 rtl/udcnt_prescaler.sv | 36 +++
 rtl/updown_counter_mod.sv | 118 +++++++++++
 tb/tb_updown_counter_mod.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/udcnt_pkg.sv
`default_nettype none
// ============================================================================
// Module      : udcnt_pkg
// Description : Shared constants for the up/down counter (boundary modes,
//               count directions, default data width).
// Revision    : 1.0 - initial release
// ============================================================================
package udcnt_pkg;

    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    localparam logic DIR_DOWN  = 1'b0;
    localparam logic DIR_UP    = 1'b1;

    localparam int DEFAULT_WIDTH = 5;

endpackage
`default_nettype wire

// File: rtl/udcnt_prescaler.sv
`default_nettype none
// ============================================================================
// Module      : udcnt_prescaler
// Description : Divides enabled cycles by PRESCALE; step marks every
//               PRESCALE-th enabled cycle. clr restarts the phase.
// Revision    : 1.0 - initial release
// ============================================================================
module udcnt_prescaler #(
    parameter int PRESCALE = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic enab,
    output logic step
);

    localparam int            PW     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] C_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] r_pre_cnt;
    logic          w_last;

    assign w_last = (r_pre_cnt == C_LAST);
    assign step   = enab && !clr && w_last;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_pre_cnt <= '0;
        end else if (enab) begin
            r_pre_cnt <= w_last ? '0 : r_pre_cnt + PW'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/updown_counter_mod.sv
`default_nettype none
// ============================================================================
// Module      : updown_counter_mod
// Description : Up/down counter with runtime modulus, wrap/saturate modes,
//               clamped load, terminal-count pulse and sticky overflow.
//               Optional step prescaler enabled by UDCNT_PRESCALE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module updown_counter_mod
    import udcnt_pkg::*;
#(
    parameter int               WIDTH     = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int               PRESCALE  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enab,
    input  logic             load,
    input  logic             up_dn,
    input  logic             mode,
    input  logic [WIDTH-1:0] max_val,
    input  logic [WIDTH-1:0] cnt_in,
    output logic [WIDTH-1:0] cnt_out,
    output logic             tc,
    output logic             at_max,
    output logic             at_zero,
    output logic             ovf
);

    if (WIDTH < 2) begin : g_bad_width
        $error("updown_counter_mod: WIDTH must be at least 2");
    end
    if (PRESCALE < 1) begin : g_bad_prescale
        $error("updown_counter_mod: PRESCALE must be at least 1");
    end

    logic [WIDTH-1:0] r_cnt;
    logic             r_tc;
    logic             r_ovf;
    logic [WIDTH-1:0] w_cnt_nxt;
    logic             w_tc_nxt;
    logic             w_ovf_nxt;
    logic             w_step;
    logic             w_above;

`ifdef UDCNT_PRESCALE_EN
    udcnt_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .clr  (load),
        .enab (enab),
        .step (w_step)
    );
`else
    assign w_step = enab && !load;
`endif

    // A lowered max_val can leave the count above the bound
    assign w_above = (r_cnt > max_val);

    always_comb begin
        w_cnt_nxt = r_cnt;
        w_tc_nxt  = 1'b0;
        w_ovf_nxt = r_ovf;
        if (load) begin
            w_cnt_nxt = (cnt_in > max_val) ? max_val : cnt_in;
            w_ovf_nxt = 1'b0;
        end else if (w_step) begin
            if (up_dn == DIR_UP) begin
                if (r_cnt < max_val) begin
                    w_cnt_nxt = r_cnt + WIDTH'(1);
                end else if (mode == MODE_WRAP) begin
                    w_cnt_nxt = '0;
                    w_tc_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = max_val;
                    w_tc_nxt  = 1'b1;
                    w_ovf_nxt = 1'b1;
                end
            end else begin
                if (w_above) begin
                    w_cnt_nxt = max_val;
                end else if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - WIDTH'(1);
                end else if (mode == MODE_WRAP) begin
                    w_cnt_nxt = max_val;
                    w_tc_nxt  = 1'b1;
                end else begin
                    w_tc_nxt  = 1'b1;
                    w_ovf_nxt = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= RESET_VAL;
            r_tc  <= 1'b0;
            r_ovf <= 1'b0;
        end else begin
            r_cnt <= w_cnt_nxt;
            r_tc  <= w_tc_nxt;
            r_ovf <= w_ovf_nxt;
        end
    end

    assign cnt_out = r_cnt;
    assign tc      = r_tc;
    assign ovf     = r_ovf;
    assign at_max  = (r_cnt >= max_val);
    assign at_zero = (r_cnt == '0);

endmodule
`default_nettype wire

// File: tb/tb_updown_counter_mod.sv
`default_nettype none
// ============================================================================
// Module      : tb_updown_counter_mod
// Description : Directed and randomized self-checking bench for
//               updown_counter_mod against an integer reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_updown_counter_mod;

`ifdef UDCNT_PRESCALE_EN
    localparam int PS = 4;
`else
    localparam int PS = 1;
`endif
    localparam int W    = 5;
    localparam int RVAL = 0;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         enab = 1'b0;
    logic         load = 1'b0;
    logic         up_dn = 1'b1;
    logic         mode = 1'b0;
    logic [W-1:0] max_val = '0;
    logic [W-1:0] cnt_in = '0;
    logic [W-1:0] cnt_out;
    logic         tc;
    logic         at_max;
    logic         at_zero;
    logic         ovf;

    int checks   = 0;
    int failures = 0;

    // Reference model state (plain integers)
    int m_cnt = 0;
    int m_tc  = 0;
    int m_ovf = 0;
    int m_pre = 0;
    int m_max = 0;

    updown_counter_mod #(
        .WIDTH     (W),
        .RESET_VAL (5'(RVAL)),
        .PRESCALE  (PS)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .enab    (enab),
        .load    (load),
        .up_dn   (up_dn),
        .mode    (mode),
        .max_val (max_val),
        .cnt_in  (cnt_in),
        .cnt_out (cnt_out),
        .tc      (tc),
        .at_max  (at_max),
        .at_zero (at_zero),
        .ovf     (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic model_edge(input bit r, input bit l, input bit e, input bit u,
                              input bit m, input int mv, input int ci);
        bit do_step;
        m_tc = 0;
        if (r) begin
            m_cnt = RVAL; m_ovf = 0; m_pre = 0;
        end else if (l) begin
            m_cnt = (ci > mv) ? mv : ci; m_ovf = 0; m_pre = 0;
        end else if (e) begin
            m_pre   = m_pre + 1;
            do_step = (m_pre == PS);
            if (do_step) m_pre = 0;
            if (do_step && u) begin
                if (m_cnt < mv) m_cnt = m_cnt + 1;
                else begin
                    m_tc = 1;
                    m_cnt = m ? mv : 0;
                    if (m) m_ovf = 1;
                end
            end else if (do_step) begin
                if (m_cnt > mv) m_cnt = mv;
                else if (m_cnt > 0) m_cnt = m_cnt - 1;
                else begin
                    m_tc = 1;
                    m_cnt = m ? 0 : mv;
                    if (m) m_ovf = 1;
                end
            end
        end
    endtask

    task automatic model_check(input string tag);
        chk({tag, ".cnt"}, int'(cnt_out), m_cnt);
        chk({tag, ".tc"}, int'(tc), m_tc);
        chk({tag, ".ovf"}, int'(ovf), m_ovf);
        chk({tag, ".at_max"}, int'(at_max), (m_cnt >= m_max) ? 1 : 0);
        chk({tag, ".at_zero"}, int'(at_zero), (m_cnt == 0) ? 1 : 0);
    endtask

    task automatic cyc(input string tag, input bit r, input bit l, input bit e,
                       input bit u, input bit m, input int mv, input int ci);
        rst = r; load = l; enab = e; up_dn = u; mode = m;
        max_val = mv[W-1:0]; cnt_in = ci[W-1:0];
        @(posedge clk);
        model_edge(r, l, e, u, m, mv, ci);
        m_max = mv;
        #1;
        model_check(tag);
    endtask

    initial begin
        // Reset state
        cyc("reset", 1, 0, 0, 1, 0, 9, 0);
        chk("reset.cnt_const", int'(cnt_out), RVAL);
        chk("reset.tc_const", int'(tc), 0);

`ifndef UDCNT_PRESCALE_EN
        // Count up with wrap at 9
        for (int k = 1; k <= 12; k++) begin
            cyc("up_wrap", 0, 0, 1, 1, 0, 9, 0);
            chk("up_wrap.cnt_const", int'(cnt_out), k % 10);
            chk("up_wrap.tc_const", int'(tc), (k == 10) ? 1 : 0);
            chk("up_wrap.at_max_const", int'(at_max), (k == 9) ? 1 : 0);
        end

        // Saturate down from 2
        cyc("sat_load", 0, 1, 0, 0, 1, 9, 2);
        chk("sat_load.cnt_const", int'(cnt_out), 2);
        for (int k = 1; k <= 4; k++) begin
            cyc("sat_down", 0, 0, 1, 0, 1, 9, 0);
            chk("sat_down.cnt_const", int'(cnt_out), (k >= 2) ? 0 : 1);
            chk("sat_down.tc_const", int'(tc), (k >= 3) ? 1 : 0);
            chk("sat_down.ovf_const", int'(ovf), (k >= 3) ? 1 : 0);
        end
        cyc("sat_hold", 0, 0, 0, 0, 1, 9, 0);
        chk("sat_hold.ovf_const", int'(ovf), 1);
        chk("sat_hold.tc_const", int'(tc), 0);
        cyc("sat_reload", 0, 1, 0, 0, 1, 9, 3);
        chk("sat_reload.ovf_const", int'(ovf), 0);

        // Load clamp and priority
        cyc("clamp", 0, 1, 1, 1, 0, 20, 31);
        chk("clamp.cnt_const", int'(cnt_out), 20);
        chk("clamp.tc_const", int'(tc), 0);
        cyc("rst_over_load", 1, 1, 1, 1, 0, 20, 17);
        chk("rst_over_load.cnt_const", int'(cnt_out), RVAL);

        // Runtime bound lowered below current count
        cyc("bound_load", 0, 1, 0, 1, 0, 20, 15);
        max_val = 5'd7; m_max = 7;
        #1;
        chk("bound.at_max_now", int'(at_max), 1);
        cyc("bound_up", 0, 0, 1, 1, 0, 7, 0);
        chk("bound_up.cnt_const", int'(cnt_out), 0);
        chk("bound_up.tc_const", int'(tc), 1);
        cyc("bound_load2", 0, 1, 0, 1, 0, 20, 15);
        cyc("bound_down", 0, 0, 1, 0, 0, 7, 0);
        chk("bound_down.cnt_const", int'(cnt_out), 7);
        chk("bound_down.tc_const", int'(tc), 0);

        // Reset mid-count
        cyc("mid_rst0", 1, 0, 0, 1, 0, 20, 0);
        for (int k = 1; k <= 5; k++) cyc("mid_up", 0, 0, 1, 1, 0, 20, 0);
        chk("mid_up.cnt_const", int'(cnt_out), 5);
        cyc("mid_rst", 1, 0, 1, 1, 0, 20, 0);
        chk("mid_rst.cnt_const", int'(cnt_out), RVAL);
        chk("mid_rst.tc_const", int'(tc), 0);
        cyc("mid_resume", 0, 0, 1, 1, 0, 20, 0);
        chk("mid_resume.cnt_const", int'(cnt_out), RVAL + 1);
`else
        // Prescaled stepping: one count per four enabled cycles
        cyc("ps_rst", 1, 0, 0, 1, 0, 20, 0);
        for (int k = 1; k <= 8; k++) begin
            cyc("ps_up", 0, 0, 1, 1, 0, 20, 0);
            chk("ps_up.cnt_const", int'(cnt_out), k / 4);
        end
        // Load on cycle 2 restarts the phase
        cyc("ps_rst2", 1, 0, 0, 1, 0, 20, 0);
        cyc("ps_c1", 0, 0, 1, 1, 0, 20, 0);
        cyc("ps_c2_load", 0, 1, 1, 1, 0, 20, 0);
        for (int k = 3; k <= 7; k++) begin
            cyc("ps_phase", 0, 0, 1, 1, 0, 20, 0);
            chk("ps_phase.cnt_const", int'(cnt_out), (k >= 6) ? 1 : 0);
        end
`endif

        // Randomized traffic against the model
        for (int k = 0; k < 400; k++) begin
            int mv;
            mv = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 31));
            cyc("rand",
                ($urandom_range(0, 39) == 0),
                ($urandom_range(0, 9) == 0),
                ($urandom_range(0, 3) != 0),
                1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)),
                mv,
                int'($urandom_range(0, 31)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
